// File: rtl/config_commit_controller_pkg.sv
// rtl/config_commit_controller_pkg.sv - shared types and constants for the config commit controller
package config_commit_controller_pkg;

  localparam int NUM_VOICES      = 16;
  localparam int NUM_OPERATORS   = 6;
  localparam int ALGORITHM_WIDTH = 5;
  localparam int ADDR_WIDTH      = 10;
  localparam int DATA_WIDTH      = 16;

  localparam logic [2:0] CFG_REG_PHASESTEP = 3'd0;
  localparam logic [2:0] CFG_REG_ENVLEVEL  = 3'd1;
  localparam logic [2:0] CFG_REG_WAVEFORM  = 3'd2;
  localparam logic [2:0] CFG_REG_ALGORITHM = 3'd0;
  localparam logic [2:0] CFG_OP_VOICE      = 3'd7;

  typedef struct packed {
    logic [15:0]        phase_step;
    logic signed [15:0] envelope_level;
    logic               waveform;
  } OperatorConfig_t;

  typedef struct packed {
    logic [ALGORITHM_WIDTH-1:0]          algorithm;
    OperatorConfig_t [NUM_OPERATORS-1:0] operators;
  } VoiceConfig_t;

  typedef struct packed {
    VoiceConfig_t [NUM_VOICES-1:0] voices;
  } CoreConfig_t;

  typedef enum logic [1:0] {IDLE, PENDING, DONE} CommitState_t;

endpackage

// File: rtl/config_commit_controller_shadow_bank.sv
// rtl/config_commit_controller_shadow_bank.sv - address decode, shadow config storage and sticky address error
module config_shadow_bank
  import config_commit_controller_pkg::*;
(
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_write_en,
  input  logic [ADDR_WIDTH-1:0] i_write_addr,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output CoreConfig_t           o_shadow,
  output logic                  o_addr_error
);

  CoreConfig_t shadow_q, shadow_d;
  logic        error_q, error_d;
  logic [3:0]  voice;
  logic [2:0]  op;
  logic [2:0]  sel;
  logic        addr_ok;

  always_comb begin
    voice    = i_write_addr[9:6];
    op       = i_write_addr[5:3];
    sel      = i_write_addr[2:0];
    shadow_d = shadow_q;
    error_d  = error_q;
    addr_ok  = 1'b0;
    if (op == CFG_OP_VOICE) begin
      addr_ok = (sel == CFG_REG_ALGORITHM);
    end else if (int'(op) < NUM_OPERATORS) begin
      addr_ok = (sel <= CFG_REG_WAVEFORM);
    end
    addr_ok = addr_ok && (int'(voice) < NUM_VOICES);

    // Invalid addresses still complete the handshake; the data is simply dropped.
    if (i_write_en) begin
      if (!addr_ok) begin
        error_d = 1'b1;
      end else begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (int'(voice) == v) begin
            if (op == CFG_OP_VOICE) begin
              shadow_d.voices[v].algorithm = i_write_data[ALGORITHM_WIDTH-1:0];
            end else begin
              for (int o = 0; o < NUM_OPERATORS; o++) begin
                if (int'(op) == o) begin
                  case (sel)
                    CFG_REG_PHASESTEP: shadow_d.voices[v].operators[o].phase_step     = i_write_data;
                    CFG_REG_ENVLEVEL:  shadow_d.voices[v].operators[o].envelope_level = i_write_data;
                    CFG_REG_WAVEFORM:  shadow_d.voices[v].operators[o].waveform       = i_write_data[0];
                    default: ;
                  endcase
                end
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shadow_q <= '0;
      error_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      error_q  <= error_d;
    end
  end

  assign o_shadow     = shadow_q;
  assign o_addr_error = error_q;

endmodule

// File: rtl/config_commit_controller.sv
// rtl/config_commit_controller.sv - publishes the shadow config to the core atomically at a sample boundary
module config_commit_controller
  import config_commit_controller_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_WriteValid,
  output logic                   o_WriteReady,
  input  logic [ADDR_WIDTH-1:0]  i_WriteAddr,
  input  logic [DATA_WIDTH-1:0]  i_WriteData,
  input  logic                   i_Commit,
  input  logic                   i_SampleBoundary,
  output CoreConfig_t            o_Config,
  output logic                   o_CommitPending,
  output logic                   o_CommitDone,
  output logic [COUNT_WIDTH-1:0] o_CommitCount,
  output logic                   o_AddrError
);

  CommitState_t           state_q, state_d;
  CoreConfig_t            config_q, config_d;
  CoreConfig_t            shadow;
  logic                   ready_q, ready_d;
  logic                   pending_q, pending_d;
  logic                   done_q, done_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   write_accept;

  assign o_WriteReady = ready_q && !i_Reset;
  assign write_accept = i_WriteValid && o_WriteReady;

  config_shadow_bank u_shadow_bank (
    .i_clock      (i_Clock),
    .i_reset      (i_Reset),
    .i_write_en   (write_accept),
    .i_write_addr (i_WriteAddr),
    .i_write_data (i_WriteData),
    .o_shadow     (shadow),
    .o_addr_error (o_AddrError)
  );

  always_comb begin
    state_d   = state_q;
    config_d  = config_q;
    ready_d   = ready_q;
    pending_d = pending_q;
    done_d    = done_q;
    count_d   = count_q;
    case (state_q)
      // A boundary coincident with the commit request is deliberately not used.
      IDLE: begin
        if (i_Commit) begin
          state_d   = PENDING;
          ready_d   = 1'b0;
          pending_d = 1'b1;
        end
      end
      PENDING: begin
        if (i_SampleBoundary) begin
          state_d   = DONE;
          config_d  = shadow;
          pending_d = 1'b0;
          done_d    = 1'b1;
          count_d   = count_q + COUNT_WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: begin
        state_d   = IDLE;
        ready_d   = 1'b1;
        pending_d = 1'b0;
        done_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      config_q  <= '0;
      ready_q   <= 1'b1;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      config_q  <= config_d;
      ready_q   <= ready_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  assign o_Config        = config_q;
  assign o_CommitPending = pending_q;
  assign o_CommitDone    = done_q;
  assign o_CommitCount   = count_q;

endmodule

// File: tb/tb_config_commit_controller.sv
// tb/tb_config_commit_controller.sv - self-checking bench for config_commit_controller
module tb_config_commit_controller;
  import config_commit_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [9:0]  addr = '0;
  logic [15:0] data = '0;
  logic        commit = 1'b0;
  logic        boundary = 1'b0;

  logic        ready1, pend1, done1, err1;
  logic [15:0] cnt1;
  CoreConfig_t cfg1;
  logic        ready2, pend2, done2, err2;
  logic [3:0]  cnt2;
  CoreConfig_t cfg2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  config_commit_controller dut (
    .i_Clock(clk), .i_Reset(rst), .i_WriteValid(valid), .o_WriteReady(ready1),
    .i_WriteAddr(addr), .i_WriteData(data), .i_Commit(commit), .i_SampleBoundary(boundary),
    .o_Config(cfg1), .o_CommitPending(pend1), .o_CommitDone(done1),
    .o_CommitCount(cnt1), .o_AddrError(err1)
  );

  config_commit_controller #(.COUNT_WIDTH(4)) dut_small (
    .i_Clock(clk), .i_Reset(rst), .i_WriteValid(valid), .o_WriteReady(ready2),
    .i_WriteAddr(addr), .i_WriteData(data), .i_Commit(commit), .i_SampleBoundary(boundary),
    .o_Config(cfg2), .o_CommitPending(pend2), .o_CommitDone(done2),
    .o_CommitCount(cnt2), .o_AddrError(err2)
  );

  // Reference model: register file arrays plus commit bookkeeping.
  logic [15:0] sh_phase [NUM_VOICES][NUM_OPERATORS];
  logic [15:0] sh_env   [NUM_VOICES][NUM_OPERATORS];
  logic        sh_wave  [NUM_VOICES][NUM_OPERATORS];
  logic [ALGORITHM_WIDTH-1:0] sh_alg [NUM_VOICES];
  logic [15:0] ac_phase [NUM_VOICES][NUM_OPERATORS];
  logic [15:0] ac_env   [NUM_VOICES][NUM_OPERATORS];
  logic        ac_wave  [NUM_VOICES][NUM_OPERATORS];
  logic [ALGORITHM_WIDTH-1:0] ac_alg [NUM_VOICES];
  bit m_pending, m_done, m_err;
  int m_count;

  task automatic model_reset();
    for (int v = 0; v < NUM_VOICES; v++) begin
      sh_alg[v] = '0;
      ac_alg[v] = '0;
      for (int o = 0; o < NUM_OPERATORS; o++) begin
        sh_phase[v][o] = '0; sh_env[v][o] = '0; sh_wave[v][o] = 1'b0;
        ac_phase[v][o] = '0; ac_env[v][o] = '0; ac_wave[v][o] = 1'b0;
      end
    end
    m_pending = 0; m_done = 0; m_err = 0; m_count = 0;
  endtask

  function automatic CoreConfig_t exp_cfg();
    CoreConfig_t c;
    c = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      c.voices[v].algorithm = ac_alg[v];
      for (int o = 0; o < NUM_OPERATORS; o++) begin
        c.voices[v].operators[o].phase_step     = ac_phase[v][o];
        c.voices[v].operators[o].envelope_level = ac_env[v][o];
        c.voices[v].operators[o].waveform       = ac_wave[v][o];
      end
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cfg(input string tag, input CoreConfig_t obs, input CoreConfig_t exp);
    int bad;
    checks++;
    assert (obs === exp) else begin
      errors++;
      bad = 0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) if (obs.voices[v] !== exp.voices[v]) bad = v;
      $error("FAIL %s voice %0d observed=%h expected=%h", tag, bad, obs.voices[bad], exp.voices[bad]);
    end
  endtask

  task automatic check_all();
    logic exp_ready;
    CoreConfig_t e;
    exp_ready = !rst && !m_pending && !m_done;
    e = exp_cfg();
    chk("ready", ready1, exp_ready);
    chk("pending", pend1, m_pending);
    chk("done", done1, m_done);
    chk("count", cnt1, m_count & 32'hFFFF);
    chk("addr_err", err1, m_err);
    chk_cfg("config", cfg1, e);
    chk("ready_w4", ready2, exp_ready);
    chk("pending_w4", pend2, m_pending);
    chk("done_w4", done2, m_done);
    chk("count_w4", cnt2, m_count & 32'hF);
    chk("addr_err_w4", err2, m_err);
    chk_cfg("config_w4", cfg2, e);
  endtask

  // Advance one clock, apply the specification's rules to the model, compare everything.
  task automatic tick();
    bit rdy;
    int v, op, sel;
    rdy = !rst && !m_pending && !m_done;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (valid && rdy) begin
        v = int'(addr[9:6]); op = int'(addr[5:3]); sel = int'(addr[2:0]);
        if (op == 7 && sel == 0) sh_alg[v] = data[ALGORITHM_WIDTH-1:0];
        else if (op < 6 && sel == 0) sh_phase[v][op] = data;
        else if (op < 6 && sel == 1) sh_env[v][op] = data;
        else if (op < 6 && sel == 2) sh_wave[v][op] = data[0];
        else m_err = 1;
      end
      if (m_done) begin
        m_done = 0;
      end else if (m_pending) begin
        if (boundary) begin
          ac_phase = sh_phase; ac_env = sh_env; ac_wave = sh_wave; ac_alg = sh_alg;
          m_pending = 0; m_done = 1; m_count++;
        end
      end else if (commit) begin
        m_pending = 1;
      end
    end
    check_all();
  endtask

  task automatic write(input logic [9:0] a, input logic [15:0] d);
    valid = 1'b1; addr = a; data = d;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset state, including ready low while reset is held.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_count", cnt1, 0);
    chk("reset_ready", ready1, 1);

    // Write without commit: active config must not move.
    write({4'd3, 3'd2, 3'd0}, 16'h1234);
    repeat (200) tick();
    chk("no_commit_ps", cfg1.voices[3].operators[2].phase_step, 16'h0000);
    chk("no_commit_pend", pend1, 0);

    // Commit then boundary ten cycles later.
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (9) tick();
    chk("wait_pend", pend1, 1);
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    chk("commit_ps", cfg1.voices[3].operators[2].phase_step, 16'h1234);
    chk("commit_done", done1, 1);
    tick();
    chk("done_once", done1, 0);
    chk("count_one", cnt1, 1);

    // Commit coincident with a boundary waits for the following boundary.
    write({4'd3, 3'd2, 3'd0}, 16'h5678);
    commit = 1'b1; boundary = 1'b1;
    tick();
    commit = 1'b0; boundary = 1'b0;
    chk("same_cycle_ps", cfg1.voices[3].operators[2].phase_step, 16'h1234);
    repeat (95) tick();
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    chk("second_bnd_ps", cfg1.voices[3].operators[2].phase_step, 16'h5678);
    tick();

    // Invalid addresses: operator 6, then voice-level register 3.
    write({4'd1, 3'd6, 3'd0}, 16'hAAAA);
    chk("err_op6", err1, 1);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    write({4'd1, 3'd7, 3'd3}, 16'h001F);
    chk("err_vreg3", err1, 1);
    commit = 1'b1; tick(); commit = 1'b0;
    boundary = 1'b1; tick(); boundary = 1'b0; tick();
    chk("err_alg", cfg1.voices[1].algorithm, 0);

    // Reset while pending discards the commit.
    write({4'd5, 3'd1, 3'd1}, 16'h7FFF);
    commit = 1'b1; tick(); commit = 1'b0;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("rst_env", cfg1.voices[5].operators[1].envelope_level, 0);
    chk("rst_done", done1, 0);
    chk("rst_count", cnt1, 0);
    chk("rst_ready", ready1, 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      valid    = ($urandom_range(0, 1) == 1);
      addr     = {4'($urandom), 3'($urandom), 3'($urandom_range(0, 3))};
      data     = 16'($urandom);
      commit   = ($urandom_range(0, 19) == 0);
      boundary = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    valid = 1'b0; commit = 1'b0; boundary = 1'b0;

    // Counter wrap, observed on the narrow instance.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 1; i <= 20; i++) begin
      commit = 1'b1; tick(); commit = 1'b0;
      boundary = 1'b1; tick(); boundary = 1'b0;
      tick();
      if (i == 16) chk("wrap_w4", cnt2, 0);
    end
    chk("count_20", cnt1, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_commit_controller.md
Name: config_commit_controller

Overview:
- Host-side configuration controller for `core`.
- Accepts single-register writes into a shadow copy of the full voice/operator configuration over a valid/ready handshake.
- On a host commit request, copies the shadow copy into the active `CoreConfig_t` driving `core.i_Config`, atomically, at the next sample boundary.
- Result: the core never renders a sample from a partially updated voice.

Parameters:
- NUM_VOICES, 16, voices per sample; must match core sequencing.
- NUM_OPERATORS, 6, operators per voice; must match core sequencing.
- COUNT_WIDTH, 16, width of the commit counter.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_WriteValid  in  1  write request valid.
- o_WriteReady  out  1  controller can accept a write this cycle.
- i_WriteAddr  in  10  register address: [9:6] voice, [5:3] operator (7 = voice-level), [2:0] register select.
- i_WriteData  in  16  write data; narrower fields use the LSBs.
- i_Commit  in  1  one-cycle request to publish the shadow copy.
- i_SampleBoundary  in  1  connected to `core.o_SampleReady`.
- o_Config  out  CoreConfig_t  active configuration, registered; drives `core.i_Config`.
- o_CommitPending  out  1  high while a commit waits for a boundary.
- o_CommitDone  out  1  one-cycle pulse in the cycle after active config updates.
- o_CommitCount  out  COUNT_WIDTH  number of completed commits; wraps.
- o_AddrError  out  1  sticky; set by any accepted write to an invalid address.

Behaviour:
- Reset (i_Reset high at a clock edge):
  - Shadow and active config all zero.
  - State IDLE; o_CommitPending=0, o_CommitDone=0, o_CommitCount=0, o_AddrError=0.
  - o_WriteReady=0 during any cycle with i_Reset high.
- Address decode, operator level (op 0..5):
  - reg 0 = PhaseStep[15:0].
  - reg 1 = EnvelopeLevel (signed 16).
  - reg 2 = Waveform (data[0]).
- Address decode, voice level (op 7):
  - reg 0 = Algorithm (data[ALGORITHM_WIDTH-1:0]).
- Invalid addresses: op 6, voice >= NUM_VOICES, or an unmapped reg.
  - The write is accepted (handshake completes) but dropped.
  - o_AddrError is set the next cycle and stays set until reset.
- Write acceptance: a write completes when i_WriteValid && o_WriteReady at the clock edge. The shadow field updates at that edge, one write per cycle.
- State IDLE:
  - o_WriteReady=1.
  - On i_Commit, go to PENDING next cycle. A write accepted in the same cycle as i_Commit is included in the commit.
  - i_SampleBoundary in the same cycle as i_Commit does NOT commit; the commit waits for the next boundary.
- State PENDING:
  - o_WriteReady=0, so the snapshot is frozen. o_CommitPending=1.
  - Additional i_Commit pulses are ignored (no queueing).
  - On i_SampleBoundary, o_Config <= shadow at that edge and go to DONE.
  - Timing: the core's cycle counter is 0 in the next cycle, so operator 0 / voice 0 of the next sample sees the new config.
- State DONE (one cycle):
  - o_CommitDone=1; o_CommitCount increments (wraps 0xFFFF->0); o_WriteReady=0.
  - Unconditional return to IDLE. i_Commit in DONE is ignored.
- Active config changes only on the commit edge. o_Config is held constant in all other cycles, including while the shadow is being written.
- Shadow is not cleared by a commit; it retains values for incremental edits.
- Reset mid-PENDING or mid-DONE:
  - Return to IDLE; active config goes to zero.
  - The pending commit is discarded; o_CommitDone does not pulse.
- Commit latency from i_Commit to o_CommitDone is 2 + N cycles, where N = cycles from the PENDING entry to the first boundary (N >= 0).

Decomposition:
- Add to the `core.svh` package:
  - register-select constants CFG_REG_PHASESTEP=0, CFG_REG_ENVLEVEL=1, CFG_REG_WAVEFORM=2, CFG_REG_ALGORITHM=0.
  - CFG_OP_VOICE=7.
  - state enum CommitState_t {IDLE, PENDING, DONE}.
  - ALGORITHM_WIDTH.
- Reuse the existing CoreConfig_t, VoiceConfig_t and OperatorConfig_t.
- One sub-module, config_shadow_bank: address decode, shadow storage and the error flag. Its outputs are the shadow CoreConfig_t and a decode-error strobe.
- The FSM, active register and counter live in the top module.

Test Plan:
- Reset, then write addr {v=3, op=2, reg=0} data 0x1234, with no commit for 200 cycles -> o_Config voice 3 op 2 PhaseStep stays 0x0000; o_CommitPending=0.
- Same write, then i_Commit pulse, then i_SampleBoundary 10 cycles later:
  - o_CommitPending=1 for those cycles;
  - PhaseStep becomes 0x1234 at the boundary edge;
  - o_CommitDone pulses once the next cycle;
  - o_CommitCount=1.
- i_Commit and i_SampleBoundary in the same cycle, next boundary 96 cycles later -> no update at the first boundary; update at the second; o_WriteReady=0 throughout PENDING.
- Write to op=6, and separately to voice-level reg 3 -> handshake completes, o_AddrError=1, o_Config unchanged after a subsequent commit.
- Assert i_Reset while PENDING after writing EnvelopeLevel 0x7FFF -> o_Config all zero, no o_CommitDone, o_CommitCount=0, IDLE with o_WriteReady=1 the cycle after reset deasserts.
- Preload o_CommitCount to 0xFFFF by 65535 commits, then commit again -> o_CommitCount wraps to 0x0000.
